// File: rtl/pong_scoreboard.sv
// Pong scoreboard: per-player BCD score counters, win detection and
// seven-segment drive for HEX0..HEX7 with a blinking winner in WON.
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_PLAY  | game running, goal pulses increment scores
// ST_WON   | a player reached WIN_SCORE; scores frozen, winner blinks
module pong_scoreboard #(
  parameter int WIN_SCORE = 11,
  parameter int CLK_HZ    = 50_000_000,
  parameter int BLINK_HZ  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       goal_left,
  input  logic       goal_right,
  input  logic       new_game,
  output logic       game_over,
  output logic       winner,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5,
  output logic [6:0] hex6,
  output logic [6:0] hex7
);

  localparam int BLINK_N = CLK_HZ / (2 * BLINK_HZ);
  localparam int CW      = (BLINK_N > 1) ? $clog2(BLINK_N) : 1;
  localparam logic [CW-1:0] BLINK_TC = CW'(BLINK_N - 1);
  localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {ST_PLAY, ST_WON} state_t;

  state_t        state, state_next;
  logic [7:0]    score_left, score_left_next;
  logic [7:0]    score_right, score_right_next;
  logic [CW-1:0] blink_cnt, blink_cnt_next;
  logic          phase, phase_next;
  logic          game_over_next, winner_next;
  logic [7:0]    left_inc, right_inc;
  logic          left_win, right_win;
  logic          blank_left, blank_right;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
  endfunction

  // Scores never pass WIN_SCORE (<= 99), so the tens digit cannot overflow.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign left_inc  = bcd_inc(score_left);
  assign right_inc = bcd_inc(score_right);
  assign left_win  = goal_left  && (left_inc  == WIN_BCD);
  assign right_win = goal_right && (right_inc == WIN_BCD);

  // State, scores, winner flags and blink timer registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= ST_PLAY;
      score_left  <= 8'h00;
      score_right <= 8'h00;
      blink_cnt   <= '0;
      phase       <= 1'b1;
      game_over   <= 1'b0;
      winner      <= 1'b0;
    end else begin
      state       <= state_next;
      score_left  <= score_left_next;
      score_right <= score_right_next;
      blink_cnt   <= blink_cnt_next;
      phase       <= phase_next;
      game_over   <= game_over_next;
      winner      <= winner_next;
    end
  end

  // Next-state logic: scoring and win detection in PLAY, blink timing in WON.
  always_comb begin
    state_next       = state;
    score_left_next  = score_left;
    score_right_next = score_right;
    blink_cnt_next   = blink_cnt;
    phase_next       = phase;
    game_over_next   = game_over;
    winner_next      = winner;
    case (state)
      ST_PLAY: begin
        blink_cnt_next = '0;
        phase_next     = 1'b1;
        if (new_game) begin
          score_left_next  = 8'h00;
          score_right_next = 8'h00;
        end else begin
          if (goal_left)  score_left_next  = left_inc;
          if (goal_right) score_right_next = right_inc;
          if (left_win || right_win) begin
            state_next     = ST_WON;
            game_over_next = 1'b1;
            // A simultaneous double win goes to the left player.
            winner_next    = !left_win;
          end
        end
      end
      ST_WON: begin
        if (new_game) begin
          state_next       = ST_PLAY;
          score_left_next  = 8'h00;
          score_right_next = 8'h00;
          game_over_next   = 1'b0;
          winner_next      = 1'b0;
          blink_cnt_next   = '0;
          phase_next       = 1'b1;
        end else if (blink_cnt == BLINK_TC) begin
          blink_cnt_next = '0;
          phase_next     = !phase;
        end else begin
          blink_cnt_next = blink_cnt + 1'b1;
        end
      end
      default: state_next = ST_PLAY;
    endcase
  end

  assign blank_left  = (state == ST_WON) && !phase && !winner;
  assign blank_right = (state == ST_WON) && !phase &&  winner;

  // Registered display drive, one cycle behind the score/state registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hex0 <= 7'h40;
      hex1 <= SEG_BLANK;
      hex2 <= SEG_BLANK;
      hex3 <= SEG_BLANK;
      hex4 <= SEG_BLANK;
      hex5 <= SEG_BLANK;
      hex6 <= 7'h40;
      hex7 <= SEG_BLANK;
    end else begin
      hex7 <= (blank_left || score_left[7:4] == 4'd0) ? SEG_BLANK : seg(score_left[7:4]);
      hex6 <= blank_left ? SEG_BLANK : seg(score_left[3:0]);
      hex1 <= (blank_right || score_right[7:4] == 4'd0) ? SEG_BLANK : seg(score_right[7:4]);
      hex0 <= blank_right ? SEG_BLANK : seg(score_right[3:0]);
      hex5 <= SEG_BLANK;
      hex3 <= SEG_BLANK;
      hex2 <= SEG_BLANK;
      if (state == ST_WON) hex4 <= winner ? 7'h24 : 7'h79;
      else                 hex4 <= SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_pong_scoreboard.sv
// Directed bench for pong_scoreboard with a fast blink (4 cycles per phase).
module tb_pong_scoreboard;

  logic       clock;
  logic       reset;
  logic       goal_left;
  logic       goal_right;
  logic       new_game;
  logic       game_over;
  logic       winner;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

  int n_checks = 0;
  int n_pass   = 0;

  pong_scoreboard #(.WIN_SCORE(11), .CLK_HZ(8), .BLINK_HZ(1)) dut (
    .clock      (clock),
    .reset      (reset),
    .goal_left  (goal_left),
    .goal_right (goal_right),
    .new_game   (new_game),
    .game_over  (game_over),
    .winner     (winner),
    .hex0       (hex0),
    .hex1       (hex1),
    .hex2       (hex2),
    .hex3       (hex3),
    .hex4       (hex4),
    .hex5       (hex5),
    .hex6       (hex6),
    .hex7       (hex7)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic gl, input logic gr, input logic ng);
    goal_left  = gl;
    goal_right = gr;
    new_game   = ng;
    tick();
    goal_left  = 1'b0;
    goal_right = 1'b0;
    new_game   = 1'b0;
  endtask

  task automatic goals(input int n_left, input int n_right);
    for (int i = 0; i < n_left; i++)  pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < n_right; i++) pulse(1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hex0"}, hex0, 7'h40);
    check({tag, "_hex1"}, hex1, 7'h7F);
    check({tag, "_hex2"}, hex2, 7'h7F);
    check({tag, "_hex3"}, hex3, 7'h7F);
    check({tag, "_hex4"}, hex4, 7'h7F);
    check({tag, "_hex5"}, hex5, 7'h7F);
    check({tag, "_hex6"}, hex6, 7'h40);
    check({tag, "_hex7"}, hex7, 7'h7F);
    check({tag, "_game_over"}, game_over, 1'b0);
    check({tag, "_winner"}, winner, 1'b0);
  endtask

  initial begin
    logic       vis;
    logic [6:0] exp_r;

    reset      = 1'b0;
    goal_left  = 1'b0;
    goal_right = 1'b0;
    new_game   = 1'b0;
    tick();
    tick();
    check_reset_outputs("rst");

    // 1: left 1, right 3
    reset = 1'b1;
    goals(1, 3);
    tick();
    check("t1_hex6", hex6, 7'h79);
    check("t1_hex0", hex0, 7'h30);
    check("t1_hex7", hex7, 7'h7F);
    check("t1_hex1", hex1, 7'h7F);
    check("t1_hex4", hex4, 7'h7F);
    check("t1_game_over", game_over, 1'b0);

    // new_game beats a simultaneous goal
    pulse(1'b1, 1'b1, 1'b1);
    tick();
    check("ng_goal_hex6", hex6, 7'h40);
    check("ng_goal_hex0", hex0, 7'h40);

    // 2: ten left goals, BCD carry 9->10
    goals(10, 0);
    tick();
    check("t2_hex7", hex7, 7'h79);
    check("t2_hex6", hex6, 7'h40);
    check("t2_hex0", hex0, 7'h40);
    check("t2_game_over", game_over, 1'b0);

    // 3: both at 10, simultaneous goal -> both 11, left wins
    goals(0, 10);
    check("t3_pre_game_over", game_over, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    check("t3_game_over", game_over, 1'b1);
    check("t3_winner", winner, 1'b0);
    tick();
    check("t3_hex4", hex4, 7'h79);
    check("t3_hex7", hex7, 7'h79);
    check("t3_hex6", hex6, 7'h79);
    check("t3_hex1", hex1, 7'h79);
    check("t3_hex0", hex0, 7'h79);

    // 4: fresh game, left 5, right reaches 11 and blinks
    pulse(1'b0, 1'b0, 1'b1);
    check("t4_ng_game_over", game_over, 1'b0);
    goals(5, 10);
    check("t4_pre_game_over", game_over, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check("t4_game_over", game_over, 1'b1);
    check("t4_winner", winner, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      goal_left  = (k == 2);
      goal_right = (k == 3);
      tick();
      vis   = (((k - 1) / 4) % 2) == 0;
      exp_r = vis ? 7'h79 : 7'h7F;
      check($sformatf("t4_blink%0d_hex0", k), hex0, exp_r);
      check($sformatf("t4_blink%0d_hex1", k), hex1, exp_r);
      check($sformatf("t4_blink%0d_hex6", k), hex6, 7'h12);
      check($sformatf("t4_blink%0d_hex4", k), hex4, 7'h24);
    end
    goal_left  = 1'b0;
    goal_right = 1'b0;
    check("t4_hex7", hex7, 7'h7F);
    check("t4_frozen_game_over", game_over, 1'b1);

    // 5: new_game from WON
    pulse(1'b0, 1'b0, 1'b1);
    check("t5_game_over", game_over, 1'b0);
    check("t5_winner", winner, 1'b0);
    tick();
    check("t5_hex0", hex0, 7'h40);
    check("t5_hex6", hex6, 7'h40);
    check("t5_hex4", hex4, 7'h7F);
    check("t5_hex1", hex1, 7'h7F);

    // 6: reset mid-game at 5/7 together with a goal pulse
    goals(5, 7);
    tick();
    check("t6_pre_hex6", hex6, 7'h12);
    check("t6_pre_hex0", hex0, 7'h78);
    reset     = 1'b0;
    goal_left = 1'b1;
    tick();
    reset     = 1'b1;
    goal_left = 1'b0;
    check_reset_outputs("t6_rst");
    tick();
    check("t6_post_hex6", hex6, 7'h40);
    check("t6_post_hex0", hex0, 7'h40);
    check("t6_post_game_over", game_over, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
